// File: rtl/inst_encoder_loader.sv
// Streaming MIPS instruction encoder that assembles 32-bit words from symbolic
// fields and writes them contiguously into instruction memory from address 0.
module inst_encoder_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_FULL = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  // Builds the machine word the control unit decodes; unused fields drop out.
  function automatic logic [31:0] encode_word(
    input logic [3:0]  mnem,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    case (mnem)
      4'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      4'd1:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      4'd2:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100011};
      4'd3:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      4'd4:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b101011};
      4'd5:    w = {6'b001101, rs, rt, imm};
      4'd6:    w = {6'b001001, rs, rt, imm};
      4'd7:    w = {6'b100011, rs, rt, imm};
      4'd8:    w = {6'b101011, rs, rt, imm};
      4'd9:    w = {6'b000100, rs, rt, imm};
      4'd10:   w = {6'b000010, target};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  logic [1:0]        state_r;
  logic [ADDR_W:0]   count_r;
  logic              err_r;
  logic              im_we_r;
  logic [ADDR_W-1:0] im_addr_r;
  logic [31:0]       im_wdata_r;

  logic              accept_s;
  logic              legal_s;
  logic [ADDR_W:0]   count_inc_s;
  logic [31:0]       enc_s;

  // Transfer qualification and encoding of the word presented this cycle.
  always_comb begin
    accept_s    = (state_r == ST_LOAD) && in_valid;
    legal_s     = (in_mnem <= 4'd10);
    count_inc_s = count_r + ONE_C;
    enc_s       = encode_word(in_mnem, in_rs, in_rt, in_rd, in_imm, in_target);
  end

  // Session FSM, write pointer/count, sticky error and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      count_r    <= '0;
      err_r      <= 1'b0;
      im_we_r    <= 1'b0;
      im_addr_r  <= '0;
      im_wdata_r <= 32'h0000_0000;
    end else begin
      im_we_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE, ST_FULL: begin
          if (start) begin
            state_r <= ST_LOAD;
            count_r <= '0;
            err_r   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            if (legal_s) begin
              im_we_r    <= 1'b1;
              im_addr_r  <= count_r[ADDR_W-1:0];
              im_wdata_r <= enc_s;
              count_r    <= count_inc_s;
            end else begin
              err_r <= 1'b1;
            end
            // Last word ends the session even when it also fills memory.
            if (in_last) begin
              state_r <= ST_DONE;
            end else if (legal_s && (count_inc_s == DEPTH_C)) begin
              state_r <= ST_FULL;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = (state_r == ST_LOAD);
  assign busy     = (state_r == ST_LOAD);
  assign done     = (state_r == ST_DONE);
  assign full     = (state_r == ST_FULL);
  assign err      = err_r;
  assign count    = count_r;
  assign im_we    = im_we_r;
  assign im_addr  = im_addr_r;
  assign im_wdata = im_wdata_r;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader with hand-computed MIPS encodings,
// run with DEPTH=4 so the full-memory boundary is reachable.
module tb_inst_encoder_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              full;
  logic              err;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int wr_cnt   = 0;
  int wr_base  = 0;

  inst_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .count(count), .busy(busy), .done(done), .full(full), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts write strobes seen mid-cycle so extra or missing writes show up.
  always @(negedge clk) begin
    if (im_we === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [15:0] imm,
                          input logic [25:0] tgt, input logic last);
    in_mnem   = m;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_target = tgt;
    in_last   = last;
  endtask

  task automatic check_write(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    check_val({tag, "_we"}, {31'd0, im_we}, 32'd1);
    check_val({tag, "_addr"}, {22'd0, im_addr}, {22'd0, a});
    check_val({tag, "_data"}, im_wdata, d);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [31:0] exp_b2b [3];
  logic [31:0] exp_fill [4];
  logic [31:0] exp_tog [3];

  initial begin
    exp_b2b[0]  = 32'h8C08_0004;
    exp_b2b[1]  = 32'h1022_FFFF;
    exp_b2b[2]  = 32'h0800_0010;
    exp_fill[0] = 32'h2401_0001;
    exp_fill[1] = 32'h2402_0002;
    exp_fill[2] = 32'h2403_0003;
    exp_fill[3] = 32'h2404_0004;
    exp_tog[0]  = 32'h00E8_482A;
    exp_tog[1]  = 32'h014B_602B;
    exp_tog[2]  = 32'h03FE_E823;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    set_word(4'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Reset state
    check_val("rst_ready", {31'd0, in_ready}, 32'd0);
    check_val("rst_we", {31'd0, im_we}, 32'd0);
    check_val("rst_flags", {28'd0, busy, done, full, err}, 32'd0);
    check_val("rst_count", {21'd0, count}, 32'd0);
    check_val("rst_addr", {22'd0, im_addr}, 32'd0);
    check_val("rst_data", im_wdata, 32'd0);

    // Single add with last
    do_start();
    check_val("s1_busy", {31'd0, busy}, 32'd1);
    check_val("s1_ready", {31'd0, in_ready}, 32'd1);
    wr_base = wr_cnt;
    set_word(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_write("add", 10'd0, 32'h0022_1820);
    check_val("add_done", {31'd0, done}, 32'd1);
    check_val("add_count", {21'd0, count}, 32'd1);
    tick();
    check_val("add_we_drop", {31'd0, im_we}, 32'd0);
    check_val("add_wr_n", wr_cnt - wr_base, 32'd1);

    // Back-to-back lw, beq, j(last)
    do_start();
    wr_base = wr_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       set_word(4'd7, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0);
        1:       set_word(4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b0);
        default: set_word(4'd10, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0000010, 1'b1);
      endcase
      tick();
      check_write($sformatf("b2b%0d", i), i[ADDR_W-1:0], exp_b2b[i]);
    end
    check_val("b2b_count", {21'd0, count}, 32'd3);
    check_val("b2b_done", {31'd0, done}, 32'd1);

    // Restart from DONE with in_valid already high: only start acts
    set_word(4'd1, 5'd4, 5'd5, 5'd6, 16'h0000, 26'h0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("rs_we", {31'd0, im_we}, 32'd0);
    check_val("rs_ready", {31'd0, in_ready}, 32'd1);
    check_val("rs_count", {21'd0, count}, 32'd0);
    check_val("b2b_wr_n", wr_cnt - wr_base, 32'd3);

    // Legal, illegal mnemonic 12, legal(last)
    wr_base = wr_cnt;
    tick();
    check_write("il0", 10'd0, 32'h0085_3022);
    set_word(4'd12, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h0, 1'b0);
    tick();
    check_val("il1_we", {31'd0, im_we}, 32'd0);
    check_val("il1_err", {31'd0, err}, 32'd1);
    check_val("il1_count", {21'd0, count}, 32'd1);
    set_word(4'd5, 5'd1, 5'd2, 5'd0, 16'h00FF, 26'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    check_write("il2", 10'd1, 32'h3422_00FF);
    check_val("il2_flags", {28'd0, busy, done, full, err}, 32'b0101);
    check_val("il2_count", {21'd0, count}, 32'd2);
    tick();
    check_val("il_wr_n", wr_cnt - wr_base, 32'd2);

    // Fill to DEPTH without last; fifth word must be refused
    do_start();
    check_val("fill_err_clr", {31'd0, err}, 32'd0);
    wr_base = wr_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_word(4'd6, 5'd0, 5'(i + 1), 5'd0, 16'(i + 1), 26'h0, 1'b0);
      tick();
      check_write($sformatf("fill%0d", i), i[ADDR_W-1:0], exp_fill[i]);
    end
    check_val("fill_full", {31'd0, full}, 32'd1);
    check_val("fill_ready", {31'd0, in_ready}, 32'd0);
    check_val("fill_count", {21'd0, count}, 32'd4);
    set_word(4'd6, 5'd0, 5'd5, 5'd0, 16'h0005, 26'h0, 1'b0);
    tick();
    check_val("fill5_we", {31'd0, im_we}, 32'd0);
    check_val("fill5_count", {21'd0, count}, 32'd4);
    in_valid = 1'b0;
    tick();
    check_val("fill_wr_n", wr_cnt - wr_base, 32'd4);
    do_start();
    check_val("fill_rs_flags", {28'd0, busy, done, full, err}, 32'b1000);
    check_val("fill_rs_count", {21'd0, count}, 32'd0);

    // in_valid toggling: slt, sltu, subu(last)
    wr_base = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       set_word(4'd3, 5'd7, 5'd8, 5'd9, 16'h0000, 26'h0, 1'b0);
        1:       set_word(4'd4, 5'd10, 5'd11, 5'd12, 16'h0000, 26'h0, 1'b0);
        default: set_word(4'd2, 5'd31, 5'd30, 5'd29, 16'h0000, 26'h0, 1'b1);
      endcase
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check_write($sformatf("tog%0d", i), i[ADDR_W-1:0], exp_tog[i]);
      tick();
      check_val($sformatf("tog%0d_idle", i), {31'd0, im_we}, 32'd0);
    end
    check_val("tog_count", {21'd0, count}, 32'd3);
    check_val("tog_wr_n", wr_cnt - wr_base, 32'd3);

    // Reset in the cycle after an accept discards the pending write
    do_start();
    wr_base = wr_cnt;
    set_word(4'd8, 5'd29, 5'd31, 5'd0, 16'h0010, 26'h0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_val("ar_we", {31'd0, im_we}, 32'd0);
    check_val("ar_flags", {27'd0, in_ready, busy, done, full, err}, 32'd0);
    check_val("ar_count", {21'd0, count}, 32'd0);
    check_val("ar_addr", {22'd0, im_addr}, 32'd0);
    check_val("ar_data", im_wdata, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_val("ar_post_we", {31'd0, im_we}, 32'd0);
    check_val("ar_post_ready", {31'd0, in_ready}, 32'd0);
    check_val("ar_wr_n", wr_cnt - wr_base, 32'd0);
    do_start();
    set_word(4'd10, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h3FFFFFF, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_write("ar_j", 10'd0, 32'h0BFF_FFFF);
    check_val("ar_j_done", {31'd0, done}, 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/inst_encoder_loader.md
# inst_encoder_loader

Streaming instruction encoder and instruction-memory loader: the encoding counterpart of the control-unit decoder. It accepts symbolic instructions (mnemonic code plus register and immediate fields) over a valid/ready handshake. It assembles the exact 32-bit MIPS words the control unit decodes and writes them sequentially into instruction memory through a synchronous write port. It sits between the test/boot sequencer and the instruction memory, ahead of the datapath.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- DEPTH, 1024, number of words loadable (2 ≤ DEPTH ≤ 2^ADDR_W)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  arm a load session; honoured only in IDLE, DONE or FULL
- in_valid  in  1  input instruction present
- in_ready  out  1  encoder can accept this cycle
- in_mnem  in  4  0 add, 1 sub, 2 subu, 3 slt, 4 sltu, 5 ori, 6 addiu, 7 lw, 8 sw, 9 beq, 10 j; 11–15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate for I-type
- in_target  in  26  jump target for j
- in_last  in  1  marks final instruction of session
- im_we  out  1  instruction-memory write strobe
- im_addr  out  ADDR_W  write word address
- im_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  legal words accepted this session
- busy  out  1  state is LOAD
- done  out  1  state is DONE
- full  out  1  state is FULL
- err  out  1  sticky: an illegal mnemonic was consumed this session

## Operation
- States: IDLE (after reset), LOAD, DONE, FULL.
- IDLE/DONE/FULL + start → LOAD. Same edge clears ptr/count to 0 and err to 0. start in LOAD is ignored.
- in_ready = 1 only in LOAD. A transfer occurs when in_valid & in_ready are both high at a rising edge.
- R-type encoding (mnem 0–4): {6'b000000, rs, rt, rd, 5'b00000, func}. func values: add 100000, sub 100010, subu 100011, slt 101010, sltu 101011.
- I-type encoding: {op, rs, rt, imm}. op values: ori 001101, addiu 001001, lw 100011, sw 101011, beq 000100. in_rd is ignored.
- j encoding: {6'b000010, target}. rs, rt, rd and imm are ignored.
- Accepting a legal word:
  - Registers im_wdata = encoding and im_addr = ptr.
  - Asserts im_we the following cycle.
  - ptr and count increment by 1 at the accept edge.
- Accepting an illegal word (mnem 11–15):
  - Consumed without a write; im_we stays 0.
  - ptr and count are unchanged.
  - err is set at that edge.
- in_last accepted (legal or illegal) → DONE. The pending write for that word still issues.
- A legal accept that makes ptr == DEPTH without in_last → FULL. in_ready then drops and no further words are accepted.
- A legal accept with in_last that makes ptr == DEPTH → DONE; DONE takes priority over FULL.
- Addresses are contiguous from 0; ptr never wraps.

## Timing
- Throughput: one instruction per cycle while in_valid stays high in LOAD.
- Latency: accept edge N → im_we = 1 with valid im_addr/im_wdata during cycle N+1, for exactly one cycle per legal word.
- busy/done/full/err/count are registered and reflect an accept edge in the following cycle.
- Reset values: state IDLE; in_ready, im_we, busy, done, full, err = 0; im_addr, im_wdata, count = 0.
- rst asserted mid-session: all outputs reach reset values immediately (asynchronously). A pending write is discarded and is not issued after rst releases.
- start and in_valid in the same cycle while in DONE: only start acts; in_ready rises the next cycle.

## Test plan
- start, then add rs=1 rt=2 rd=3 with in_last → im_we at addr 0, im_wdata 0x00221820; done=1; count=1.
- Back-to-back lw rs=0 rt=8 imm=0x0004, beq rs=1 rt=2 imm=0xFFFF, j target=0x0000010 (last) → three consecutive im_we cycles: addr 0 = 0x8C080004, addr 1 = 0x1022FFFF, addr 2 = 0x08000010; count=3; done=1.
- Legal, mnem=12, legal(last) → writes at addr 0 and 1 only; err=1; count=2; done=1.
- DEPTH=4, five words without in_last, in_valid held high → writes at addr 0–3; full=1 and in_ready=0 after the 4th accept; 5th word not accepted; count=4. Then start → LOAD, count=0, err=0.
- in_valid toggling 1/0 each cycle → writes follow each accept by exactly one cycle; addresses remain contiguous.
- rst asserted in the cycle after an accept → im_we stays 0; all outputs 0; state IDLE. After release, start plus one word (last) writes addr 0.
